float_accumulator_12bit: RTL and testbench



---
 rtl/float_accumulator_12bit_pkg.sv | 19 +
 rtl/Float_Adder_12bit.sv | 37 +++
 rtl/float_accumulator_12bit_operand_order.sv | 27 ++
 rtl/float_accumulator_12bit.sv | 117 +++++++++++
 tb/tb_float_accumulator_12bit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/float_accumulator_12bit_pkg.sv
// Shared field layout, saturation value and FSM encoding for the 12-bit
// float accumulator.
package float_accumulator_12bit_pkg;

    localparam int SIGN_BIT = 11;
    localparam int EXP_MSB  = 10;
    localparam int EXP_LSB  = 7;
    localparam int FRAC_W   = 7;

    localparam logic [11:0] SAT_VALUE = 12'h7FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACCUM = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/Float_Adder_12bit.sv
// Combinational unsigned 12-bit float adder. Format: [10:7] exponent,
// [6:0] fraction, implicit leading 1, value = 1.f * 2^e. Requires XE >= YE.
// The smaller operand is aligned by the exponent gap; a gap of 8 or more
// shifts it out entirely. Mantissa carry bumps the exponent (mod 16) and the
// result is truncated. Sign bits are ignored and Z[11] is always 0.
module Float_Adder_12bit (
    input  logic [11:0] X,
    input  logic [11:0] Y,
    output logic [11:0] Z
);

    logic [3:0] gap;
    logic [7:0] mant_x;
    logic [7:0] mant_y;
    logic [7:0] mant_y_aligned;
    logic [8:0] mant_sum;
    logic [3:0] exp_inc;
    logic       unused_signs;

    assign unused_signs = X[11] ^ Y[11];

    // Align Y to X, add mantissas and renormalise on carry.
    always_comb begin
        gap            = X[10:7] - Y[10:7];
        mant_x         = {1'b1, X[6:0]};
        mant_y         = {1'b1, Y[6:0]};
        mant_y_aligned = (gap >= 4'd8) ? 8'h00 : (mant_y >> gap);
        mant_sum       = {1'b0, mant_x} + {1'b0, mant_y_aligned};
        exp_inc        = X[10:7] + 4'd1;
        if (mant_sum[8]) begin
            Z = {1'b0, exp_inc, mant_sum[7:1]};
        end else begin
            Z = {1'b0, X[10:7], mant_sum[6:0]};
        end
    end

endmodule

// File: rtl/float_accumulator_12bit_operand_order.sv
// Exponent compare and swap: the operand with the larger (or equal) exponent
// goes to x so the downstream adder always sees XE >= YE. Signs forced to 0.
module float_operand_order
    import float_accumulator_12bit_pkg::*;
(
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic [11:0] x,
    output logic [11:0] y
);

    logic unused_signs;

    assign unused_signs = a[SIGN_BIT] ^ b[SIGN_BIT];

    // Ties keep a on the x side.
    always_comb begin
        if (a[EXP_MSB:EXP_LSB] >= b[EXP_MSB:EXP_LSB]) begin
            x = {1'b0, a[EXP_MSB:EXP_LSB], a[FRAC_W-1:0]};
            y = {1'b0, b[EXP_MSB:EXP_LSB], b[FRAC_W-1:0]};
        end else begin
            x = {1'b0, b[EXP_MSB:EXP_LSB], b[FRAC_W-1:0]};
            y = {1'b0, a[EXP_MSB:EXP_LSB], a[FRAC_W-1:0]};
        end
    end

endmodule

// File: rtl/float_accumulator_12bit.sv
// Sums N_TERMS unsigned 12-bit floats per start pulse and presents the result
// on a valid/ready output.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready and out_valid are pure decodes of the state register,
// so neither depends combinationally on any input.
module float_accumulator_12bit
    import float_accumulator_12bit_pkg::*;
#(
    parameter int N_TERMS = 8,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_data,
    output logic        overflow,
    output logic        busy
);

    state_t             state;
    state_t             state_nxt;
    logic [11:0]        acc;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_inc;
    logic [11:0]        op_x;
    logic [11:0]        op_y;
    logic [11:0]        sum_z;
    logic               sum_ovf;
    logic               unused_sign;

    assign unused_sign = in_data[SIGN_BIT];

    float_operand_order u_order (
        .a (acc),
        .b (in_data),
        .x (op_x),
        .y (op_y)
    );

    Float_Adder_12bit u_adder (
        .X (op_x),
        .Y (op_y),
        .Z (sum_z)
    );

    // Exponent wrapped past 15 on a mantissa carry.
    assign sum_ovf   = (sum_z[EXP_MSB:EXP_LSB] < op_x[EXP_MSB:EXP_LSB]);
    assign count_inc = count + CNT_W'(1);

    assign in_ready  = (state == LOAD) || (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign out_data  = acc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; stalls on either side simply hold the state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD:  if (in_valid) state_nxt = (N_TERMS == 1) ? HOLD : ACCUM;
            ACCUM: if (in_valid && (count_inc == CNT_W'(N_TERMS))) state_nxt = HOLD;
            HOLD:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator, term counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= 12'h000;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        acc   <= {1'b0, in_data[EXP_MSB:0]};
                        count <= CNT_W'(1);
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (sum_ovf) begin
                            acc      <= SAT_VALUE;
                            overflow <= 1'b1;
                        end else begin
                            acc <= sum_z;
                        end
                        count <= count_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_accumulator_12bit.sv
module tb_float_accumulator_12bit;

    logic clk;
    logic rst_n;

    logic        s2_start, s2_in_valid, s2_in_ready, s2_out_valid, s2_out_ready;
    logic        s2_overflow, s2_busy;
    logic [11:0] s2_in_data, s2_out_data;

    logic        s8_start, s8_in_valid, s8_in_ready, s8_out_valid, s8_out_ready;
    logic        s8_overflow, s8_busy;
    logic [11:0] s8_in_data, s8_out_data;

    int n_cmp = 0;
    int n_bad = 0;

    // {overflow, out_data} expected per completed accumulation
    logic [12:0] exp_q2[$];
    logic [12:0] exp_q8[$];
    logic [12:0] e2, e8;

    float_accumulator_12bit #(.N_TERMS(2), .CNT_W(4)) d2 (
        .clk(clk), .rst_n(rst_n), .start(s2_start), .in_valid(s2_in_valid),
        .in_ready(s2_in_ready), .in_data(s2_in_data), .out_valid(s2_out_valid),
        .out_ready(s2_out_ready), .out_data(s2_out_data), .overflow(s2_overflow),
        .busy(s2_busy)
    );

    float_accumulator_12bit #(.N_TERMS(8), .CNT_W(4)) d8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .in_valid(s8_in_valid),
        .in_ready(s8_in_ready), .in_data(s8_in_data), .out_valid(s8_out_valid),
        .out_ready(s8_out_ready), .out_data(s8_out_data), .overflow(s8_overflow),
        .busy(s8_busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got timeout required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge, well away from both edges.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic rdy(input int w);
        return (w == 2) ? s2_in_ready : s8_in_ready;
    endfunction

    task automatic do_start(input int w);
        if (w == 2) s2_start = 1'b1; else s8_start = 1'b1;
        tick();
        s2_start = 1'b0;
        s8_start = 1'b0;
    endtask

    task automatic send(input int w, input logic [11:0] d);
        for (int g = 0; g < 50 && !rdy(w); g++) tick();
        if (!rdy(w)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got 0 required 1 (dut %0d)", w);
        end
        if (w == 2) begin s2_in_valid = 1'b1; s2_in_data = d; end
        else        begin s8_in_valid = 1'b1; s8_in_data = d; end
        tick();
        s2_in_valid = 1'b0;
        s8_in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int w);
        for (int g = 0; g < 50 && ((w == 2) ? exp_q2.size() : exp_q8.size()) > 0; g++) tick();
        check("drain", 16'((w == 2) ? exp_q2.size() : exp_q8.size()), 16'd0);
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (rst_n && s2_out_valid && s2_out_ready) begin
            if (exp_q2.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL d2_unexpected_out: got %h required none", s2_out_data);
            end else begin
                e2 = exp_q2.pop_front();
                check("d2_result", {3'b0, s2_overflow, s2_out_data}, {3'b0, e2});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s8_out_valid && s8_out_ready) begin
            if (exp_q8.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL d8_unexpected_out: got %h required none", s8_out_data);
            end else begin
                e8 = exp_q8.pop_front();
                check("d8_result", {3'b0, s8_overflow, s8_out_data}, {3'b0, e8});
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [11:0] acc_exp [8];
    logic [11:0] mix_in  [8];

    initial begin
        acc_exp = '{12'h000, 12'h080, 12'h0C0, 12'h100, 12'h120, 12'h140, 12'h160, 12'h180};
        mix_in  = '{12'h000, 12'h180, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};

        rst_n = 1'b0;
        s2_start = 0; s2_in_valid = 0; s2_in_data = '0; s2_out_ready = 1;
        s8_start = 0; s8_in_valid = 0; s8_in_data = '0; s8_out_ready = 1;

        // Reset values
        #3;
        check("rst_in_ready",  {15'b0, s2_in_ready},  16'd0);
        check("rst_out_valid", {15'b0, s2_out_valid}, 16'd0);
        check("rst_out_data",  {4'b0, s8_out_data},   16'h000);
        check("rst_overflow",  {15'b0, s8_overflow},  16'd0);
        check("rst_busy",      {15'b0, s8_busy},      16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 8.0 + 8.0 = 16.0, out_valid the cycle after the 2nd transfer
        do_start(2);
        check("t1_busy", {15'b0, s2_busy}, 16'd1);
        send(2, 12'h180);
        check("t1_not_early", {15'b0, s2_out_valid}, 16'd0);
        exp_q2.push_back({1'b0, 12'h200});
        send(2, 12'h180);
        check("t1_latency", {15'b0, s2_out_valid}, 16'd1);
        wait_drain(2);

        // Exponent overflow saturates and stays sticky until next start
        do_start(2);
        send(2, 12'h780);
        exp_q2.push_back({1'b1, 12'h7FF});
        send(2, 12'h780);
        check("t4_overflow_hold", {15'b0, s2_overflow}, 16'd1);
        wait_drain(2);
        check("t4_sticky_idle", {15'b0, s2_overflow}, 16'd1);
        do_start(2);
        check("t4_start_clears", {15'b0, s2_overflow}, 16'd0);

        // 4.0 then 8.0 requires swap; input stalls in between
        send(2, 12'h100);
        exp_q2.push_back({1'b0, 12'h1C0});
        tick(); tick(); tick();
        check("t2_stall_ready", {15'b0, s2_in_ready}, 16'd1);
        send(2, 12'h180);
        wait_drain(2);

        // Exponent gap 7: 128 + 1 = 129 ; gap 8: 256 + 1 -> 256
        do_start(2);
        send(2, 12'h380);
        exp_q2.push_back({1'b0, 12'h381});
        send(2, 12'h000);
        wait_drain(2);
        do_start(2);
        send(2, 12'h000);
        exp_q2.push_back({1'b0, 12'h400});
        send(2, 12'h400);
        wait_drain(2);

        // Eight 1.0 terms with intermediate accumulator values
        do_start(8);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_q8.push_back({1'b0, 12'h180});
            send(8, 12'h000);
            check($sformatf("t3_acc_%0d", i), {4'b0, d8.acc}, {4'b0, acc_exp[i]});
        end
        wait_drain(8);

        // Backpressure in HOLD with an ignored start pulse
        do_start(2);
        send(2, 12'h180);
        s2_out_ready = 1'b0;
        exp_q2.push_back({1'b0, 12'h1C0});
        send(2, 12'h100);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) s2_start = 1'b1;
            tick();
            s2_start = 1'b0;
            check("t5_valid_held", {15'b0, s2_out_valid}, 16'd1);
            check("t5_data_held",  {4'b0, s2_out_data},   16'h1C0);
            check("t5_no_in_ready", {15'b0, s2_in_ready}, 16'd0);
        end
        s2_out_ready = 1'b1;
        tick();
        s2_out_ready = 1'b0;
        check("t5_valid_drop", {15'b0, s2_out_valid}, 16'd0);
        check("t5_idle",       {15'b0, s2_busy},      16'd0);
        check("t5_popped",     16'(exp_q2.size()),    16'd0);
        s2_out_ready = 1'b1;

        // Asynchronous reset mid-ACCUM after 3 terms
        do_start(8);
        send(8, 12'h000);
        send(8, 12'h000);
        send(8, 12'h000);
        check("t6_busy_before", {15'b0, s8_busy}, 16'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", {15'b0, s8_out_valid}, 16'd0);
        check("t6_rst_in_ready",  {15'b0, s8_in_ready},  16'd0);
        check("t6_rst_busy",      {15'b0, s8_busy},      16'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fresh sum after reset: 1 + 8 + six 1.0 = 15 -> 1.875 * 2^3
        do_start(8);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_q8.push_back({1'b0, 12'h1F0});
            send(8, mix_in[i]);
        end
        wait_drain(8);
        check("t6_final_ovf", {15'b0, s8_overflow}, 16'd0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
